// File: rtl/vt_escape_parser_if.sv
// Byte-stream bus for vt_escape_parser: serial bytes in, character and command strobes out.
interface vt_escape_parser_if;
  logic       serwr;
  logic [7:0] serdata;
  logic       chwr;
  logic [7:0] chdata;
  logic       cmdwr;
  logic [2:0] cmd;
  logic [6:0] arg0;
  logic [6:0] arg1;

  modport master (
    output serwr, serdata,
    input  chwr, chdata, cmdwr, cmd, arg0, arg1
  );

  modport slave (
    input  serwr, serdata,
    output chwr, chdata, cmdwr, cmd, arg0, arg1
  );
endinterface

// File: rtl/vt_escape_parser.sv
// VT100/ANSI escape decoder: passes characters through, turns escape sequences into command strobes.
// Define VTPARSE_CURSOR_MOVE_EN to decode the CSI A/B/C/D cursor-motion finals.
module vt_escape_parser #(
  parameter int ROWS = 25,
  parameter int COLS = 80
) (
  input  logic              clk25,
  input  logic              rst,
  vt_escape_parser_if.slave bus
);

  typedef enum logic [1:0] {ST_GROUND, ST_ESC, ST_CSI} state_t;
  typedef enum logic [2:0] {CUP, ED, EL, CUU, CUD, CUF, CUB, RIS} cmd_t;

  localparam logic [7:0] ROWS_M = 8'(ROWS);
  localparam logic [7:0] COLS_M = 8'(COLS);
  localparam logic [7:0] B_ESC  = 8'h1B;
  localparam logic [7:0] B_CAN  = 8'h18;
  localparam logic [7:0] B_SUB  = 8'h1A;

  state_t     state, state_n;
  logic [7:0] p0, p0_n, p1, p1_n;
  logic       pidx, pidx_n, ign, ign_n;
  logic       chwr_n, cmdwr_n;
  logic [7:0] chdata_n;
  logic [2:0] cmd_n;
  logic [6:0] arg0_n, arg1_n;

  logic [7:0]  b;
  logic        is_digit, is_abort;
  logic [7:0]  cur;
  logic [11:0] acc;
  logic [7:0]  acc_sat;
  logic [7:0]  row_lo, row_c, col_lo, col_c;

  assign b        = bus.serdata;
  assign is_digit = (b >= 8'h30) && (b <= 8'h39);
  assign is_abort = (b == B_CAN) || (b == B_SUB);

  // Accumulators saturate at 255 so oversized arguments still clamp correctly.
  assign cur     = pidx ? p1 : p0;
  assign acc     = {4'd0, cur} * 12'd10 + {8'd0, b[3:0]};
  assign acc_sat = (acc > 12'd255) ? 8'hFF : acc[7:0];

  assign row_lo = (p0 == 8'd0) ? 8'd1 : p0;
  assign row_c  = (row_lo > ROWS_M) ? ROWS_M : row_lo;
  assign col_lo = (p1 == 8'd0) ? 8'd1 : p1;
  assign col_c  = (col_lo > COLS_M) ? COLS_M : col_lo;

`ifdef VTPARSE_CURSOR_MOVE_EN
  logic [7:0] cnt_c;
  assign cnt_c = (row_lo > COLS_M) ? COLS_M : row_lo;
`endif

  always_comb begin
    state_n  = state;
    p0_n     = p0;
    p1_n     = p1;
    pidx_n   = pidx;
    ign_n    = ign;
    chwr_n   = 1'b0;
    chdata_n = bus.chdata;
    cmdwr_n  = 1'b0;
    cmd_n    = bus.cmd;
    arg0_n   = bus.arg0;
    arg1_n   = bus.arg1;
    if (bus.serwr) begin
      unique case (state)
        ST_GROUND: begin
          if (b == B_ESC) begin
            state_n = ST_ESC;
          end else if (!is_abort) begin
            chwr_n   = 1'b1;
            chdata_n = b;
          end
        end
        ST_ESC: begin
          if (b == 8'h5B) begin
            state_n = ST_CSI;
            p0_n    = '0;
            p1_n    = '0;
            pidx_n  = 1'b0;
            ign_n   = 1'b0;
          end else if (b == 8'h63) begin
            state_n = ST_GROUND;
            cmdwr_n = 1'b1;
            cmd_n   = RIS;
            arg0_n  = '0;
            arg1_n  = '0;
          end else if (b != B_ESC) begin
            state_n = ST_GROUND;
          end
        end
        ST_CSI: begin
          if (is_digit) begin
            if (pidx) p1_n = acc_sat;
            else      p0_n = acc_sat;
          end else if (b == 8'h3B) begin
            if (pidx) ign_n  = 1'b1;
            else      pidx_n = 1'b1;
          end else if ((b >= 8'h20) && (b <= 8'h3F)) begin
            ign_n = 1'b1;
          end else if (b == B_ESC) begin
            state_n = ST_ESC;
          end else if (is_abort) begin
            state_n = ST_GROUND;
          end else if (b < 8'h20) begin
            chwr_n   = 1'b1;
            chdata_n = b;
          end else if ((b >= 8'h40) && (b <= 8'h7E)) begin
            state_n = ST_GROUND;
            if (!ign) begin
              unique case (b)
                8'h48, 8'h66: begin
                  cmdwr_n = 1'b1;
                  cmd_n   = CUP;
                  arg0_n  = 7'(row_c - 8'd1);
                  arg1_n  = 7'(col_c - 8'd1);
                end
                8'h4A, 8'h4B: begin
                  if (p0 <= 8'd2) begin
                    cmdwr_n = 1'b1;
                    cmd_n   = (b == 8'h4A) ? ED : EL;
                    arg0_n  = p0[6:0];
                    arg1_n  = '0;
                  end
                end
`ifdef VTPARSE_CURSOR_MOVE_EN
                8'h41, 8'h42, 8'h43, 8'h44: begin
                  cmdwr_n = 1'b1;
                  cmd_n   = 3'(b[2:0] + 3'd2);
                  arg0_n  = 7'(cnt_c);
                  arg1_n  = '0;
                end
`endif
                default: ;
              endcase
            end
          end
        end
        default: state_n = ST_GROUND;
      endcase
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state      <= ST_GROUND;
      p0         <= '0;
      p1         <= '0;
      pidx       <= 1'b0;
      ign        <= 1'b0;
      bus.chwr   <= 1'b0;
      bus.chdata <= '0;
      bus.cmdwr  <= 1'b0;
      bus.cmd    <= '0;
      bus.arg0   <= '0;
      bus.arg1   <= '0;
    end else begin
      state      <= state_n;
      p0         <= p0_n;
      p1         <= p1_n;
      pidx       <= pidx_n;
      ign        <= ign_n;
      bus.chwr   <= chwr_n;
      bus.chdata <= chdata_n;
      bus.cmdwr  <= cmdwr_n;
      bus.cmd    <= cmd_n;
      bus.arg0   <= arg0_n;
      bus.arg1   <= arg1_n;
    end
  end

endmodule

// File: tb/tb_vt_escape_parser.sv
// Table-driven cycle-accurate bench for vt_escape_parser; one vector per input cycle.
module tb_vt_escape_parser;

  logic clk25 = 1'b0;
  logic rst;
  vt_escape_parser_if bus ();

  vt_escape_parser #(.ROWS(25), .COLS(80)) dut (
    .clk25 (clk25),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #20 clk25 = ~clk25;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] data;
    logic       exp_ch;
    logic [7:0] exp_chdata;
    logic       exp_cmd;
    logic [2:0] exp_code;
    logic [6:0] exp_a0;
    logic [6:0] exp_a1;
  } vec_t;

  vec_t vecs[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic [7:0] d, input logic ec, input logic [7:0] ecd,
                     input logic em, input logic [2:0] code, input logic [6:0] a0, input logic [6:0] a1);
    vec_t v;
    v.rst = r; v.wr = w; v.data = d; v.exp_ch = ec; v.exp_chdata = ecd;
    v.exp_cmd = em; v.exp_code = code; v.exp_a0 = a0; v.exp_a1 = a1;
    vecs.push_back(v);
  endtask

  task automatic q(input logic [7:0] d);
    add(1'b0, 1'b1, d, 1'b0, 8'h00, 1'b0, 3'd0, 7'd0, 7'd0);
  endtask

  task automatic qs(input string s);
    for (int i = 0; i < s.len(); i++) q(s[i]);
  endtask

  task automatic ch(input logic [7:0] d);
    add(1'b0, 1'b1, d, 1'b1, d, 1'b0, 3'd0, 7'd0, 7'd0);
  endtask

  task automatic cm(input logic [7:0] d, input logic [2:0] code, input logic [6:0] a0, input logic [6:0] a1);
    add(1'b0, 1'b1, d, 1'b0, 8'h00, 1'b1, code, a0, a1);
  endtask

  task automatic idle();
    add(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 7'd0, 7'd0);
  endtask

  task automatic rs();
    add(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 7'd0, 7'd0);
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    chk("chwr", idx, {7'd0, bus.chwr}, {7'd0, v.exp_ch});
    chk("cmdwr", idx, {7'd0, bus.cmdwr}, {7'd0, v.exp_cmd});
    if (v.exp_ch) chk("chdata", idx, bus.chdata, v.exp_chdata);
    if (v.exp_cmd) begin
      chk("cmd", idx, {5'd0, bus.cmd}, {5'd0, v.exp_code});
      chk("arg0", idx, {1'b0, bus.arg0}, {1'b0, v.exp_a0});
      chk("arg1", idx, {1'b0, bus.arg1}, {1'b0, v.exp_a1});
    end
  endtask

  initial begin
    // Consecutive plain characters.
    ch("H"); ch("i"); ch(8'h0D); ch(8'h0A);
    // Cursor positioning with clamping and saturation.
    q(8'h1B); qs("[12;40"); cm("H", 3'd0, 7'd11, 7'd39);
    q(8'h1B); qs("[");      cm("H", 3'd0, 7'd0, 7'd0);
    q(8'h1B); qs("[99;300"); cm("H", 3'd0, 7'd24, 7'd79);
    q(8'h1B); qs("[999999;5"); cm("H", 3'd0, 7'd24, 7'd4);
    q(8'h1B); qs("[5;0");   cm("f", 3'd0, 7'd4, 7'd0);
    idle();
    // Erase commands and discarded sequences.
    q(8'h1B); qs("[2");     cm("J", 3'd1, 7'd2, 7'd0);
    q(8'h1B); qs("[");      cm("K", 3'd2, 7'd0, 7'd0);
    q(8'h1B); qs("[5J");
    q(8'h1B); qs("[1;2;3H");
    q(8'h1B); qs("[?1H");
    q(8'h1B); qs("[1Z");
    q(8'h1B);               cm("c", 3'd7, 7'd0, 7'd0);
    q(8'h1B); q(8'h1B); qs("[1"); cm("K", 3'd2, 7'd1, 7'd0);
`ifdef VTPARSE_CURSOR_MOVE_EN
    q(8'h1B); qs("[");      cm("C", 3'd5, 7'd1, 7'd0);
    q(8'h1B); qs("[0");     cm("A", 3'd3, 7'd1, 7'd0);
    q(8'h1B); qs("[200");   cm("D", 3'd6, 7'd80, 7'd0);
    q(8'h1B); qs("[7");     cm("B", 3'd4, 7'd7, 7'd0);
`else
    q(8'h1B); qs("[3B");    ch("x");
    q(8'h1B); qs("[C");     ch("y");
`endif
    // CAN/SUB handling and control pass-through inside CSI.
    q(8'h18); q(8'h1A); ch("q");
    q(8'h1B); q("x");       ch("y");
    q(8'h1B); q(8'h18);     ch("[");
    q(8'h1B); qs("[1"); q(8'h18); ch("Z");
    q(8'h1B); qs("[1"); ch(8'h0A); cm("H", 3'd0, 7'd0, 7'd0);
    // Reset mid-sequence drops the partial sequence.
    q(8'h1B); qs("[3"); rs(); ch("J");
  end

  initial begin
    rst = 1'b1;
    bus.serwr = 1'b0;
    bus.serdata = 8'h00;
    @(negedge clk25);
    @(negedge clk25);
    chk("rst_chwr", -1, {7'd0, bus.chwr}, 8'h00);
    chk("rst_cmdwr", -1, {7'd0, bus.cmdwr}, 8'h00);
    chk("rst_chdata", -1, bus.chdata, 8'h00);
    chk("rst_cmd", -1, {5'd0, bus.cmd}, 8'h00);
    chk("rst_arg0", -1, {1'b0, bus.arg0}, 8'h00);
    chk("rst_arg1", -1, {1'b0, bus.arg1}, 8'h00);
    rst = 1'b0;

    for (int i = 0; i <= vecs.size(); i++) begin
      @(negedge clk25);
      if (i > 0) check_vec(vecs[i-1], i - 1);
      if (i < vecs.size()) begin
        rst = vecs[i].rst;
        bus.serwr = vecs[i].wr;
        bus.serdata = vecs[i].data;
      end else begin
        rst = 1'b0;
        bus.serwr = 1'b0;
      end
    end

    // Reset wins over a simultaneous byte, and clears held output data.
    @(negedge clk25);
    rst = 1'b1; bus.serwr = 1'b1; bus.serdata = "A";
    @(negedge clk25);
    chk("rstwr_chwr", -2, {7'd0, bus.chwr}, 8'h00);
    chk("rstwr_chdata", -2, bus.chdata, 8'h00);
    rst = 1'b0; bus.serwr = 1'b1; bus.serdata = "B";
    @(negedge clk25);
    bus.serwr = 1'b0;
    chk("post_chwr", -3, {7'd0, bus.chwr}, 8'h01);
    chk("post_chdata", -3, bus.chdata, 8'h42);
    @(negedge clk25);
    chk("hold_chwr", -4, {7'd0, bus.chwr}, 8'h00);
    chk("hold_chdata", -4, bus.chdata, 8'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vt_escape_parser.md
# vt_escape_parser

Byte-stream decoder between the serial receiver and the screen-writer state machine in the terminal. It consumes received bytes (`serwr`/`serdata`) and splits them into two streams:
- printable and control characters, passed through unchanged to the character writer;
- VT100/ANSI escape sequences (cursor positioning, erase, cursor motion, reset), which are decoded into single-cycle command strobes with clamped arguments.

The downstream writer never sees ESC or CSI bytes.

## Interface
Parameters:
- `ROWS`, 25, screen rows; row arguments clamp to ROWS-1.
- `COLS`, 80, screen columns; column and count arguments clamp to COLS-1 or COLS.

Ports:
- `clk25`  in  1  system clock, 25 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `serwr`  in  1  input byte strobe; one byte per cycle maximum.
- `serdata`  in  8  input byte, valid when `serwr`=1.
- `chwr`  out  1  pass-through character strobe, one cycle wide.
- `chdata`  out  8  pass-through byte, valid with `chwr`.
- `cmdwr`  out  1  decoded-command strobe, one cycle wide.
- `cmd`  out  3  command code: 0 CUP, 1 ED, 2 EL, 3 CUU, 4 CUD, 5 CUF, 6 CUB, 7 RIS.
- `arg0`  out  7  first argument: row, count or erase mode.
- `arg1`  out  7  second argument: column for CUP, otherwise 0.

## Operation
States: GROUND, ESC, CSI.

GROUND:
- 0x1B → ESC.
- 0x18 (CAN) and 0x1A (SUB) are dropped.
- Every other byte → `chwr`/`chdata`.

ESC:
- `[` → CSI; clears p0, p1, pidx and ign.
- `c` → cmdwr with RIS, args 0; → GROUND.
- 0x1B → stays in ESC.
- CAN/SUB → GROUND.
- Any other byte is discarded; → GROUND.

CSI:
- Digit: p[pidx] = sat255(p[pidx]*10 + d). The accumulators are 8-bit and saturate at 255.
- `;`: pidx increments. A third or later parameter sets ign.
- Any other byte 0x20–0x3F: sets ign.
- Control byte (<0x20) other than ESC/CAN/SUB: passed through on `chwr`; state unchanged.
- ESC: restart → ESC. CAN/SUB: abort → GROUND, no output.
- Final byte 0x40–0x7E: → GROUND. If ign=1 the sequence is discarded. Otherwise decode:
  - `H` or `f` → CUP. arg0 = min(max(p0,1),ROWS)-1; arg1 = min(max(p1,1),COLS)-1.
  - `J` → ED, arg0 = p0. Only p0 in {0,1,2} emits; other values are discarded.
  - `K` → EL, same rule as ED.
  - `A`/`B`/`C`/`D` → CUU/CUD/CUF/CUB. arg0 = min(max(p0,1),COLS); arg1 = 0.
  - Any other final byte → discarded.
- Omitted parameters read as 0.

## Timing
- Reset values:
  - all outputs 0;
  - state GROUND;
  - p0, p1, pidx, ign cleared.
- Latency: one cycle. Byte accepted at edge N (`serwr`=1) → `chwr` or `cmdwr` high during cycle N+1 only.
- `chwr` and `cmdwr` are never high in the same cycle.
- `chdata`, `cmd` and args hold their values until the next strobe.
- Back-to-back bytes on consecutive cycles must be accepted with no stalls and no drops. There is no backpressure; the downstream writer must accept one strobe per cycle.
- `rst` takes priority over a simultaneous `serwr`: that byte is lost.
- Reset mid-sequence discards the partial sequence. The next byte is parsed from GROUND.
- Argument arithmetic is unsigned. Clamping is done on 8-bit values before truncation to 7 bits.

## Configuration
Macro: `VTPARSE_CURSOR_MOVE_EN`.
- Defined: finals `A`/`B`/`C`/`D` decode to CUU/CUD/CUF/CUB as described above.
- Undefined:
  - those finals are discarded like unknown finals;
  - `cmd` codes 3–6 are never produced;
  - CUP, ED, EL and RIS are unaffected.

## Test plan
- Send "Hi\r\n" on consecutive cycles → four `chwr` pulses on consecutive cycles: 0x48, 0x69, 0x0D, 0x0A. No `cmdwr`.
- Send "ESC[12;40H" → one `cmdwr`: cmd=0, arg0=11, arg1=39. Then "ESC[H" → cmd=0, arg0=0, arg1=0. Then "ESC[99;300H" → arg0=24, arg1=79.
- Send "ESC[2J" → cmd=1, arg0=2. "ESC[K" → cmd=2, arg0=0. "ESC[5J" → no strobe. "ESC[1;2;3H" → no strobe. "ESCc" → cmd=7.
- With macro defined: "ESC[C" → cmd=5, arg0=1. "ESC[0A" → cmd=3, arg0=1. "ESC[200D" → cmd=6, arg0=80.
- With macro undefined: "ESC[3B" → no strobe, and the following 'x' passes through as 0x78.
- Aborts and resets:
  - "ESC[1" then CAN then 'Z' → single `chwr` 0x5A.
  - "ESC[1" then 0x0A then 'H' → `chwr` 0x0A, then `cmdwr` cmd=0 with args 0,0.
  - Assert `rst` after "ESC[3", then send "J" → `chwr` 0x4A.
